fib_index_finder: RTL and testbench
===================================

FIB_INDEX_FINDER -- requirements
Module: fib_index_finder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of the input value (legal range 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL indicate that value carries a query.
REQ-005 in_ready  output  1  SHALL indicate that the block can accept a query.
REQ-006 value  input  WIDTH  SHALL be the unsigned query value.
REQ-007 out_valid  output  1  SHALL indicate that the result outputs are valid.
REQ-008 out_ready  input  1  SHALL indicate that downstream accepts the result.
REQ-009 is_fib  output  1  SHALL be 1 when the query value is a Fibonacci number.
REQ-010 index  output  8  SHALL be the result index, as defined in REQ-016.
REQ-011 busy  output  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-012 Sequence definition SHALL be F0=0, F1=1, Fk=Fk-1+Fk-2.
REQ-013 The FSM SHALL have three states: IDLE, SEARCH and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on in_valid&&in_ready the block SHALL:
- latch value;
- load a=F0=0, b=F1=1, k=0;
- go to SEARCH.
REQ-015 In SEARCH, each cycle SHALL compare a with the latched value (unsigned):
- a==value: is_fib<=1, index<=k, go to DONE;
- a>value: is_fib<=0, index<=k, go to DONE;
- otherwise: a<=b, b<=a+b, k<=k+1, stay in SEARCH.
REQ-016 Index meaning SHALL be:
- Fibonacci value: the smallest k with Fk==value, so value 1 gives index 1, never 2;
- non-Fibonacci value: the smallest k with Fk>value.
REQ-017 The registers a and b SHALL be WIDTH+1 bits wide, so that the first Fibonacci number above 2^WIDTH-1 is represented without wrap-around.
REQ-018 Latency: for result index k, out_valid SHALL rise exactly k+1 clock edges after the acceptance edge.
REQ-019 In DONE:
- out_valid SHALL be 1;
- is_fib and index SHALL stay stable until out_valid&&out_ready;
- the transfer SHALL return the FSM to IDLE.
REQ-020 in_ready SHALL be 0 in SEARCH and DONE.
- No new query is accepted in the same cycle as a result transfer.
- The next acceptance is possible at the earliest one cycle after returning to IDLE.
REQ-021 Changes on value after the acceptance edge SHALL NOT affect the current search.
REQ-022 out_valid SHALL be 0 in IDLE and SEARCH.
REQ-023 is_fib and index SHALL hold the last result until the next result is written.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately force the following, independent of clk:
- state=IDLE, in_ready=1, out_valid=0, busy=0;
- is_fib=0, index=0;
- a=0, b=1, k=0.
REQ-025 A reset during SEARCH or DONE SHALL abandon the query; no result for it is ever presented.
REQ-026 After deassertion, the first rising edge with in_valid=1 SHALL accept a query.

Verification
REQ-027 value=0 -> is_fib=1, index=0, out_valid 1 edge after acceptance.
REQ-028 value=1 -> is_fib=1, index=1 (2 edges); value=233 (WIDTH=8) -> is_fib=1, index=13 (14 edges).
REQ-029 value=4 -> is_fib=0, index=5 (6 edges); value=255 -> is_fib=0, index=14, F14=377 held without wrap (15 edges).
REQ-030 value=8, out_ready held 0 for 5 cycles after out_valid rises:
- out_valid, is_fib=1 and index=6 stay stable;
- in_ready=0 throughout;
- out_ready=1 gives one transfer, then IDLE.
REQ-031 Back-to-back: value 13 then value 20 with in_valid held 1 and out_ready=1 -> (1,7) then (0,8); the second query is accepted one cycle after the first transfer.
REQ-032 Query value=200, then rst_n=0 after 5 SEARCH cycles -> out_valid=0 and in_ready=1 immediately, no result emitted; next query value=21 -> is_fib=1, index=8.

Source files
------------

// File: rtl/fib_index_finder.sv
// fib_index_finder: iterative search for the index of an unsigned value in
// the Fibonacci sequence. A query is accepted in IDLE, walked through the
// sequence one term per cycle in SEARCH, and held in DONE until taken.
module fib_index_finder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_fib,
  output logic [7:0]       index,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] val_reg, val_next;
  // One extra bit so the first term above the largest input does not wrap.
  logic [WIDTH:0]   a_reg, a_next;
  logic [WIDTH:0]   b_reg, b_next;
  logic [7:0]       k_reg, k_next;
  logic             is_fib_reg, is_fib_next;
  logic [7:0]       index_reg, index_next;

  logic [WIDTH:0]   val_ext;

  assign val_ext   = {1'b0, val_reg};
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign is_fib    = is_fib_reg;
  assign index     = index_reg;

  // State and datapath registers; reset abandons any query in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      val_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= {{WIDTH{1'b0}}, 1'b1};
      k_reg      <= 8'd0;
      is_fib_reg <= 1'b0;
      index_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      val_reg    <= val_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      k_reg      <= k_next;
      is_fib_reg <= is_fib_next;
      index_reg  <= index_next;
    end
  end

  // Next-state logic: accept, step the sequence until a >= value, then hand off.
  always_comb begin
    state_next  = state_reg;
    val_next    = val_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    k_next      = k_reg;
    is_fib_next = is_fib_reg;
    index_next  = index_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          val_next   = value;
          a_next     = '0;
          b_next     = {{WIDTH{1'b0}}, 1'b1};
          k_next     = 8'd0;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (a_reg == val_ext) begin
          is_fib_next = 1'b1;
          index_next  = k_reg;
          state_next  = DONE;
        end else if (a_reg > val_ext) begin
          is_fib_next = 1'b0;
          index_next  = k_reg;
          state_next  = DONE;
        end else begin
          // b may wrap on the final step, but it is never used after that.
          a_next = b_reg;
          b_next = a_reg + b_reg;
          k_next = k_reg + 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fib_index_finder.sv
// Directed testbench for fib_index_finder (WIDTH=8).
module tb_fib_index_finder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] value;
  logic       out_valid;
  logic       out_ready;
  logic       is_fib;
  logic [7:0] index;
  logic       busy;

  int errors;
  int checks;

  fib_index_finder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .is_fib   (is_fib),
    .index    (index),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a query for one edge, then scramble value to prove it was latched.
  task automatic accept(input logic [7:0] v);
    in_valid = 1'b1;
    value    = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    value    = ~v;
  endtask

  // Count edges until out_valid is seen; -1 when the budget runs out.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    value     = 8'd0;
    out_ready = 1'b1;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (is_fib !== 1'b0) begin errors++; $display("FAIL reset_is_fib got=%b exp=0", is_fib); end
    checks++; if (index !== 8'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", index); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
  endtask

  task automatic test_basic();
    logic [7:0] vals [6]    = '{8'd0, 8'd1, 8'd2, 8'd233, 8'd4, 8'd255};
    logic       fibs [6]    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] idxs [6]    = '{8'd0, 8'd1, 8'd3, 8'd13, 8'd5, 8'd14};
    int lat;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      accept(vals[t]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy v=%0d got=%b exp=1", vals[t], busy); end
      wait_result(lat);
      checks++; if (lat !== int'(idxs[t]) + 1) begin errors++; $display("FAIL basic_latency v=%0d got=%0d exp=%0d", vals[t], lat, int'(idxs[t]) + 1); end
      checks++; if (is_fib !== fibs[t]) begin errors++; $display("FAIL basic_is_fib v=%0d got=%b exp=%b", vals[t], is_fib, fibs[t]); end
      checks++; if (index !== idxs[t]) begin errors++; $display("FAIL basic_index v=%0d got=%0d exp=%0d", vals[t], index, idxs[t]); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_return v=%0d got out_valid=%b in_ready=%b exp 0/1", vals[t], out_valid, in_ready); end
      $display("query v=%0d -> is_fib=%b index=%0d latency=%0d", vals[t], is_fib, index, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    accept(8'd8);
    wait_result(lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL stall_latency got=%0d exp=7", lat); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", c, out_valid); end
      checks++; if (is_fib !== 1'b1 || index !== 8'd6) begin errors++; $display("FAIL stall_result cyc=%0d got=(%b,%0d) exp=(1,6)", c, is_fib, index); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_release got out_valid=%b busy=%b exp 0/0", out_valid, busy); end
    $display("stall v=8 -> is_fib=%b index=%0d held 5 cycles", is_fib, index);
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    value     = 8'd13;
    @(posedge clk);
    #1;
    value = 8'd20;
    wait_result(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=8", lat); end
    checks++; if (is_fib !== 1'b1 || index !== 8'd7) begin errors++; $display("FAIL b2b_first got=(%b,%0d) exp=(1,7)", is_fib, index); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy=%b exp=1", busy); end
    wait_result(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=9", lat); end
    checks++; if (is_fib !== 1'b0 || index !== 8'd8) begin errors++; $display("FAIL b2b_second got=(%b,%0d) exp=(0,8)", is_fib, index); end
    @(posedge clk);
    #1;
    $display("back_to_back 13 -> (1,7), 20 -> (%b,%0d)", is_fib, index);
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen;
    out_ready = 1'b1;
    accept(8'd200);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_immediate got out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
    checks++; if (is_fib !== 1'b0 || index !== 8'd0) begin errors++; $display("FAIL abort_result_clear got=(%b,%0d) exp=(0,0)", is_fib, index); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got out_valid seen=%b exp=0", seen); end
    accept(8'd21);
    wait_result(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL abort_next_latency got=%0d exp=9", lat); end
    checks++; if (is_fib !== 1'b1 || index !== 8'd8) begin errors++; $display("FAIL abort_next got=(%b,%0d) exp=(1,8)", is_fib, index); end
    @(posedge clk);
    #1;
    $display("reset_abort v=200 dropped, next v=21 -> (%b,%0d)", is_fib, index);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
